// File: rtl/serial_alu_if.sv
// serial_alu_if: operand/result handshake bundle for serial_alu.
//   in_valid / in_ready       : operand handshake (producer -> ALU)
//   a, b, op                  : operands and opcode, sampled on accept
//   out_valid / out_ready     : result handshake (ALU -> consumer)
//   result, cout, zero, sign, overflow : result word and status flags
// Modports:
//   master : the side that issues operations and consumes results
//   slave  : the ALU itself
interface serial_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zero;
  logic             sign;
  logic             overflow;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, cout, zero, sign, overflow
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, cout, zero, sign, overflow
  );
endinterface

// File: rtl/serial_alu.sv
// serial_alu: multi-cycle ALU working SLICE bits per clock, rippling the
// carry between cycles. It produces the result word plus the cout/zero/
// sign/overflow flags that the comparer turns into eql/slt.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : serial_alu_if.slave (operand and result handshakes)
// Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, others give 0.
// Result and flags are registered, loaded only when an operation
// completes, and held until the next completion.
module serial_alu #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_alu_if.slave  bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             sign_q, sign_d;
  logic             overflow_q, overflow_d;

  logic [SLICE-1:0]       a_s, b_s, b_eff, slice_res;
  logic [SLICE:0]         sum_s;
  logic                   is_arith, is_sub, last_slice, msb_cin;
  logic [WIDTH+SLICE-1:0] merged;
  logic [WIDTH-1:0]       final_res;

  // Operands are shifted right each cycle, so the active slice is always
  // the low SLICE bits; results enter the accumulator from the top, so
  // after N slices slice 0 has landed in bits [SLICE-1:0].
  always_comb begin
    a_s      = a_q[SLICE-1:0];
    b_s      = b_q[SLICE-1:0];
    is_sub   = (op_q == OP_SUB);
    is_arith = (op_q == OP_ADD) || is_sub;
    b_eff    = is_sub ? ~b_s : b_s;
    sum_s    = {1'b0, a_s} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry_q};
    case (op_q)
      OP_ADD, OP_SUB: slice_res = sum_s[SLICE-1:0];
      OP_AND:         slice_res = a_s & b_s;
      OP_OR:          slice_res = a_s | b_s;
      OP_XOR:         slice_res = a_s ^ b_s;
      default:        slice_res = '0;
    endcase
    // Carry into the MSB recovered from the sum bit and its two inputs.
    msb_cin    = sum_s[SLICE-1] ^ a_s[SLICE-1] ^ b_eff[SLICE-1];
    merged     = {slice_res, acc_q};
    final_res  = merged[WIDTH+SLICE-1:SLICE];
    last_slice = (cnt_q == CW'(N - 1));
  end

  // Next-state logic: accept in IDLE, one slice per cycle in RUN, then
  // hold the registered outputs in DONE until the consumer takes them.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    carry_d    = carry_q;
    acc_d      = acc_q;
    result_d   = result_q;
    cout_d     = cout_q;
    zero_d     = zero_q;
    sign_d     = sign_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          cnt_d   = '0;
          carry_d = (bus.op == OP_SUB);
          acc_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = final_res;
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        carry_d = is_arith ? sum_s[SLICE] : 1'b0;
        cnt_d   = cnt_q + CW'(1);
        if (last_slice) begin
          state_d    = S_DONE;
          result_d   = final_res;
          cout_d     = is_arith & sum_s[SLICE];
          overflow_d = is_arith & (msb_cin ^ sum_s[SLICE]);
          zero_d     = (final_res == '0);
          sign_d     = final_res[WIDTH-1];
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      carry_q    <= 1'b0;
      acc_q      <= '0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      zero_q     <= 1'b0;
      sign_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      carry_q    <= carry_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      zero_q     <= zero_d;
      sign_q     <= sign_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.zero      = zero_q;
  assign bus.sign      = sign_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_serial_alu.sv
// tb_serial_alu: directed bench for serial_alu (WIDTH=32, SLICE=8, N=4).
// Drives inputs on the falling edge, samples 1ns after the rising edge.
// Expected values are hand-computed constants.
module tb_serial_alu;
  localparam int WIDTH = 32;
  localparam int SLICE = 8;
  localparam int N     = WIDTH / SLICE;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;
  logic [31:0] held_res;
  logic [3:0]  held_flags;

  serial_alu_if #(.WIDTH(WIDTH)) bus ();

  serial_alu #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value with its expected value.
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [3:0] flags();
    return {bus.cout, bus.zero, bus.sign, bus.overflow};
  endfunction

  // Issues one operation, checks the N-cycle latency and the registered
  // outputs; optionally accepts the result so the ALU returns to IDLE.
  task automatic apply_stimulus(input logic [31:0] ta, input logic [31:0] tb_v, input logic [2:0] top,
                                input logic [31:0] exp_res, input logic [3:0] exp_flags,
                                input string tag, input bit release_out);
    @(negedge clk);
    check_output({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = ta;
    bus.b        = tb_v;
    bus.op       = top;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = 32'hDEAD_BEEF;
    bus.b        = 32'h1234_5678;
    for (int i = 1; i <= N; i++) begin
      @(posedge clk);
      #1;
      if (i < N) begin
        if (bus.out_valid !== 1'b0)
          check_output({tag, " early out_valid"}, 32'(bus.out_valid), 32'd0);
      end else begin
        check_output({tag, " out_valid latency"}, 32'(bus.out_valid), 32'd1);
      end
    end
    check_output({tag, " result"}, bus.result, exp_res);
    check_output({tag, " flags cout/zero/sign/ovf"}, 32'(flags()), 32'(exp_flags));
    if (release_out) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_output({tag, " in_ready after accept"}, 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    passed        = 0;
    total         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    bus.out_ready = 1'b0;
    #3;
    check_output("reset in_ready", 32'(bus.in_ready), 32'd1);
    check_output("reset out_valid", 32'(bus.out_valid), 32'd0);
    check_output("reset result", bus.result, 32'd0);
    check_output("reset flags", 32'(flags()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // flags = {cout, zero, sign, overflow}
    apply_stimulus(32'h7FFF_FFFF, 32'h0000_0001, 3'b000, 32'h8000_0000, 4'b0011, "add_ovf", 1'b1);
    apply_stimulus(32'h0000_0005, 32'h0000_0005, 3'b001, 32'h0000_0000, 4'b1100, "sub_eq", 1'b1);
    apply_stimulus(32'h0000_0003, 32'h0000_0005, 3'b001, 32'hFFFF_FFFE, 4'b0010, "sub_borrow", 1'b1);
    apply_stimulus(32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 32'h0000_0000, 4'b1100, "add_wrap", 1'b1);
    apply_stimulus(32'hA5A5_A5A5, 32'hFFFF_0000, 3'b100, 32'h5A5A_A5A5, 4'b0000, "xor", 1'b1);
    apply_stimulus(32'hA5A5_A5A5, 32'h0F0F_00FF, 3'b010, 32'h0505_00A5, 4'b0000, "and", 1'b1);
    apply_stimulus(32'h8000_0000, 32'h0000_0001, 3'b011, 32'h8000_0001, 4'b0010, "or", 1'b1);
    apply_stimulus(32'h8000_0000, 32'h0000_0001, 3'b001, 32'h7FFF_FFFF, 4'b1001, "sub_ovf", 1'b1);
    apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b111, 32'h0000_0000, 4'b0100, "reserved", 1'b1);

    // Backpressure: result must hold and new requests must be refused.
    apply_stimulus(32'h0000_0010, 32'h0000_0020, 3'b001, 32'hFFFF_FFF0, 4'b0010, "bp", 1'b0);
    held_res   = 32'hFFFF_FFF0;
    held_flags = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = ~bus.in_valid;
      bus.a        = $urandom;
      bus.op       = 3'b000;
      @(posedge clk);
      #1;
      check_output("bp in_ready", 32'(bus.in_ready), 32'd0);
      check_output("bp out_valid", 32'(bus.out_valid), 32'd1);
      check_output("bp result", bus.result, held_res);
      check_output("bp flags", 32'(flags()), 32'(held_flags));
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_output("bp release in_ready", 32'(bus.in_ready), 32'd1);
    check_output("bp release out_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    apply_stimulus(32'h1234_5678, 32'h1111_1111, 3'b000, 32'h2345_6789, 4'b0000, "after_bp", 1'b1);

    // Reset two cycles into RUN aborts the operation.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 32'h0000_0001;
    bus.b        = 32'h0000_0001;
    bus.op       = 3'b000;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("midrun rst in_ready", 32'(bus.in_ready), 32'd1);
    check_output("midrun rst out_valid", 32'(bus.out_valid), 32'd0);
    check_output("midrun rst result", bus.result, 32'd0);
    check_output("midrun rst flags", 32'(flags()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk);
      #1;
      check_output("post rst out_valid", 32'(bus.out_valid), 32'd0);
    end
    check_output("post rst in_ready", 32'(bus.in_ready), 32'd1);
    apply_stimulus(32'h0000_0002, 32'h0000_0003, 3'b000, 32'h0000_0005, 4'b0000, "add_2_3", 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
